// File: rtl/sa_pkg.sv
// sa_pkg: shared types, sizes and byte-slice helper for the result display path
package sa_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, DONE} disp_state_t;
  localparam int RES_W = 20;
  localparam int NUM_RES = 4;
  localparam int BYTES_PER_RES = 3;
  localparam int NUM_BYTES = 12;
  function automatic logic [7:0] slice_byte(input logic [23:0] w, input logic [1:0] s);
    return s == 2'd0 ? w[23:16] : s == 2'd1 ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/disp_hold_timer.sv
// disp_hold_timer: counts 0..HOLD_CYCLES-1 while enabled, flags terminal count
module disp_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  logic [W-1:0] cnt;
  assign tc = en && cnt == W'(HOLD_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset || clr || tc) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/result_display_seq.sv
// result_display_seq: captures the 2x2 result matrix and streams it out one held byte at a time
module result_display_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int RES_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid,
  input  logic [RES_W-1:0] c11,
  input  logic [RES_W-1:0] c12,
  input  logic [RES_W-1:0] c21,
  input  logic [RES_W-1:0] c22,
  input  logic             abort,
  output logic [7:0]       display_o,
  output logic             disp_valid,
  output logic [3:0]       byte_idx,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  import sa_pkg::*;
  disp_state_t state, state_n;
  logic [3:0] idx_n;
  logic [RES_W-1:0] cap_r [NUM_RES];
  logic cap_en, ovr_set, tc;
  logic [1:0] res_sel, sl;
  disp_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state != SHOW),
    .en    (state == SHOW),
    .tc    (tc)
  );
  always_comb begin
    state_n = state;
    idx_n = byte_idx;
    cap_en = 1'b0;
    ovr_set = 1'b0;
    unique case (state)
      IDLE: begin
        cap_en = res_valid;
        state_n = res_valid ? SHOW : IDLE;
        idx_n = 4'd0;
      end
      SHOW: if (tc) begin
        state_n = byte_idx == 4'(NUM_BYTES - 1) ? DONE : SHOW;
        idx_n = byte_idx == 4'(NUM_BYTES - 1) ? 4'd0 : byte_idx + 4'd1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE) begin
      ovr_set = res_valid;
      state_n = abort ? IDLE : state_n;
      idx_n = abort ? 4'd0 : idx_n;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      byte_idx <= 4'd0;
      overrun <= 1'b0;
      cap_r <= '{default: '0};
    end else begin
      state <= state_n;
      byte_idx <= idx_n;
      overrun <= overrun | ovr_set;
      if (cap_en) cap_r <= '{c11, c12, c21, c22};
    end
  assign res_sel = 2'(byte_idx / 4'(BYTES_PER_RES));
  assign sl = 2'(byte_idx % 4'(BYTES_PER_RES));
  assign display_o = state == SHOW ? slice_byte(24'(cap_r[res_sel]), sl) : 8'h00;
  assign disp_valid = state == SHOW;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_result_display_seq.sv
// tb_result_display_seq: scoreboard bench for H=4 and H=1 instances of result_display_seq
module tb_result_display_seq;
  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic [3:0] idx;
    logic       dn;
  } ent_t;
  logic clk = 0, reset = 1, rv4 = 0, rv1 = 0, abort = 0;
  logic [19:0] c11 = 0, c12 = 0, c21 = 0, c22 = 0;
  logic [7:0] d4, d1;
  logic [3:0] bi4, bi1;
  logic dv4, dv1, busy4, busy1, done4, done1, ovr4, ovr1;
  int cyc = 0, checks = 0, failures = 0, t;
  ent_t q4[$], q1[$];
  ent_t e4, e1;
  logic [7:0] exp_a [12] = '{8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF};
  logic [7:0] exp_b [12] = '{8'h00, 8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'h07, 8'hF0, 8'hF0, 8'h00, 8'h01, 8'h00};
  result_display_seq #(.HOLD_CYCLES(4), .RES_W(20)) u4 (
    .clk(clk), .reset(reset), .res_valid(rv4), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .abort(abort), .display_o(d4), .disp_valid(dv4), .byte_idx(bi4), .busy(busy4),
    .done(done4), .overrun(ovr4)
  );
  result_display_seq #(.HOLD_CYCLES(1), .RES_W(20)) u1 (
    .clk(clk), .reset(reset), .res_valid(rv1), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .abort(1'b0), .display_o(d1), .disp_valid(dv1), .byte_idx(bi1), .busy(busy1),
    .done(done1), .overrun(ovr1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask
  task automatic push(input bit to1, input int t0, input int h, input bit use_b);
    ent_t e;
    for (int k = 0; k < 12; k++)
      for (int j = 0; j < h; j++) begin
        e = '{t0 + 1 + k * h + j, use_b ? exp_b[k] : exp_a[k], 4'(k), 1'b0};
        if (to1) q1.push_back(e); else q4.push_back(e);
      end
    e = '{t0 + 12 * h + 1, 8'h00, 4'd0, 1'b1};
    if (to1) q1.push_back(e); else q4.push_back(e);
  endtask
  task automatic set_a;
    c11 = 20'h12345; c12 = 20'hABCDE; c21 = 20'h00000; c22 = 20'hFFFFF;
  endtask
  task automatic set_b;
    c11 = 20'h00001; c12 = 20'h80000; c21 = 20'h7F0F0; c22 = 20'h00100;
  endtask
  task automatic chk_idle4(input string tag);
    chk({tag, "_display"}, 32'(d4), 0);
    chk({tag, "_disp_valid"}, 32'(dv4), 0);
    chk({tag, "_byte_idx"}, 32'(bi4), 0);
    chk({tag, "_busy"}, 32'(busy4), 0);
    chk({tag, "_done"}, 32'(done4), 0);
  endtask
  always @(negedge clk)
    if (!reset && (dv4 || done4)) begin
      if (q4.size() == 0) chk("h4_unexpected_output", 32'(q4.size()), 1);
      else begin
        e4 = q4.pop_front();
        chk("h4_cycle", 32'(cyc), 32'(e4.cyc));
        chk("h4_display", 32'(d4), 32'(e4.d));
        chk("h4_byte_idx", 32'(bi4), 32'(e4.idx));
        chk("h4_done", 32'(done4), 32'(e4.dn));
        chk("h4_busy", 32'(busy4), 1);
      end
    end
  always @(negedge clk)
    if (!reset && (dv1 || done1)) begin
      if (q1.size() == 0) chk("h1_unexpected_output", 32'(q1.size()), 1);
      else begin
        e1 = q1.pop_front();
        chk("h1_cycle", 32'(cyc), 32'(e1.cyc));
        chk("h1_display", 32'(d1), 32'(e1.d));
        chk("h1_byte_idx", 32'(bi1), 32'(e1.idx));
        chk("h1_done", 32'(done1), 32'(e1.dn));
      end
    end
  initial begin
    repeat (3) tick();
    reset = 0;
    tick();
    chk_idle4("reset");
    chk("reset_overrun", 32'(ovr4), 0);
    chk("reset_h1_busy", 32'(busy1), 0);
    set_a();
    t = cyc;
    rv4 = 1; rv1 = 1;
    push(1'b0, t, 4, 1'b0);
    push(1'b1, t, 1, 1'b0);
    tick();
    rv4 = 0; rv1 = 0;
    chk("first_busy", 32'(busy4), 1);
    wait_to(t + 13);
    chk("h1_done_cycle", 32'(done1), 1);
    wait_to(t + 14);
    chk("h1_busy_after", 32'(busy1), 0);
    wait_to(t + 49);
    chk("first_done_cycle", 32'(done4), 1);
    wait_to(t + 50);
    chk_idle4("first_end");
    t = cyc;
    rv4 = 1;
    push(1'b0, t, 4, 1'b0);
    tick();
    rv4 = 0;
    chk("b2b_overrun", 32'(ovr4), 0);
    chk("b2b_busy", 32'(busy4), 1);
    wait_to(t + 10);
    set_b();
    rv4 = 1;
    tick();
    rv4 = 0;
    chk("overrun_set", 32'(ovr4), 1);
    wait_to(t + 50);
    chk_idle4("overrun_end");
    chk("overrun_sticky", 32'(ovr4), 1);
    reset = 1;
    tick();
    reset = 0;
    chk("reset_clears_overrun", 32'(ovr4), 0);
    set_a();
    t = cyc;
    rv4 = 1;
    push(1'b0, t, 4, 1'b0);
    tick();
    rv4 = 0;
    wait_to(t + 20);
    abort = 1;
    tick();
    abort = 0;
    q4.delete();
    chk_idle4("abort");
    set_b();
    t = cyc;
    rv4 = 1;
    push(1'b0, t, 4, 1'b1);
    tick();
    rv4 = 0;
    chk("after_abort_overrun", 32'(ovr4), 0);
    chk("after_abort_busy", 32'(busy4), 1);
    wait_to(t + 30);
    reset = 1;
    tick();
    reset = 0;
    q4.delete();
    chk_idle4("mid_reset");
    chk("mid_reset_overrun", 32'(ovr4), 0);
    t = cyc;
    rv4 = 1;
    push(1'b0, t, 4, 1'b1);
    tick();
    rv4 = 0;
    set_a();
    wait_to(t + 49);
    rv4 = 1;
    tick();
    rv4 = 0;
    chk("done_cycle_overrun", 32'(ovr4), 1);
    chk_idle4("done_cycle_ignored");
    repeat (10) tick();
    chk("h4_queue_drained", 32'(q4.size()), 0);
    chk("h1_queue_drained", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
